flag_unit: RTL and testbench

- Consumer end of the ALU flag interface. Holds the architectural flag register FR as {N,Z,C,V} (bit 3..0) and applies ALU flag results under a per-bit write mask.
- Saves and restores FR on a small LIFO stack for interrupt entry/return and PUSHF/POPF.
- Evaluates the 4-bit branch condition code against FR for the sequencer.
- Sits between the ALU flag outputs and the control unit/PC logic.

---
 rtl/flag_unit_if.sv | 32 +++
 rtl/flag_unit.sv | 124 ++++++++++++
 tb/tb_flag_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/flag_unit_if.sv
// Bundle between the ALU/control side and the flag unit: flag update,
// direct load, stack control, condition query and the resulting status.
interface flag_unit_if #(
    parameter int FLAG_W = 4
);
    logic [FLAG_W-1:0] alu_flags;
    logic              flag_we;
    logic [FLAG_W-1:0] flag_mask;
    logic              fr_load;
    logic [FLAG_W-1:0] fr_wdata;
    logic              push;
    logic              pop;
    logic              err_clr;
    logic [3:0]        cond;
    logic [FLAG_W-1:0] fr;
    logic              cond_true;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    modport master (
        output alu_flags, flag_we, flag_mask, fr_load, fr_wdata,
               push, pop, err_clr, cond,
        input  fr, cond_true, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  alu_flags, flag_we, flag_mask, fr_load, fr_wdata,
               push, pop, err_clr, cond,
        output fr, cond_true, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/flag_unit.sv
// Architectural flag register {N,Z,C,V} with masked ALU update, a small
// save/restore LIFO for interrupts and PUSHF/POPF, and branch condition decode.
module flag_unit #(
    parameter int FLAG_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    flag_unit_if.slave bus
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [FLAG_W-1:0] fr_reg, fr_next;
    logic [CW-1:0]     count_reg, count_next;
    logic              err_reg, err_next;
    logic [FLAG_W-1:0] stack_mem [STACK_DEPTH];

    logic [FLAG_W-1:0] masked_fr;
    logic [FLAG_W-1:0] top_val;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     wr_idx;
    logic              is_full, is_empty;
    logic              do_push, do_pop, do_swap, stack_we, err_set;

    genvar gi;
    generate
        for (gi = 0; gi < FLAG_W; gi++) begin : g_mask
            assign masked_fr[gi] = bus.flag_mask[gi] ? bus.alu_flags[gi] : fr_reg[gi];
        end
    endgenerate

    assign is_full  = (count_reg == CW'(STACK_DEPTH));
    assign is_empty = (count_reg == '0);
    assign top_idx  = AW'(count_reg - CW'(1));
    assign top_val  = stack_mem[top_idx];

    // Push+pop on an empty stack degrades to a plain push; the ignored pop flags an error.
    always_comb begin
        do_swap  = bus.push && bus.pop && !is_empty;
        do_pop   = bus.pop && !bus.push && !is_empty;
        do_push  = bus.push && ((!bus.pop && !is_full) || (bus.pop && is_empty));
        err_set  = (bus.push && !bus.pop && is_full) || (bus.pop && is_empty);
        stack_we = do_push || do_swap;
        wr_idx   = do_swap ? top_idx : AW'(count_reg);
    end

    always_comb begin
        fr_next = fr_reg;
        if (do_pop || do_swap) begin
            fr_next = top_val;
        end else if (bus.fr_load) begin
            fr_next = bus.fr_wdata;
        end else if (bus.flag_we) begin
            fr_next = masked_fr;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (do_push) begin
            count_next = count_reg + CW'(1);
        end else if (do_pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    assign err_next = err_set ? 1'b1 : (bus.err_clr ? 1'b0 : err_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fr_reg    <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            fr_reg    <= fr_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    // Storage holds the pre-update FR; contents are meaningless after reset.
    always_ff @(posedge clk) begin
        if (stack_we) begin
            stack_mem[wr_idx] <= fr_reg;
        end
    end

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_val;

    assign flag_n = fr_reg[3];
    assign flag_z = fr_reg[2];
    assign flag_c = fr_reg[1];
    assign flag_v = fr_reg[0];

    always_comb begin
        cond_val = 1'b0;
        case (bus.cond)
            4'h0: cond_val = 1'b1;
            4'h1: cond_val = flag_z;
            4'h2: cond_val = !flag_z;
            4'h3: cond_val = flag_c;
            4'h4: cond_val = !flag_c;
            4'h5: cond_val = flag_n;
            4'h6: cond_val = !flag_n;
            4'h7: cond_val = flag_v;
            4'h8: cond_val = !flag_v;
            4'h9: cond_val = !flag_c && !flag_z;
            4'hA: cond_val = flag_c || flag_z;
            4'hB: cond_val = (flag_n == flag_v);
            4'hC: cond_val = (flag_n != flag_v);
            4'hD: cond_val = !flag_z && (flag_n == flag_v);
            4'hE: cond_val = flag_z || (flag_n != flag_v);
            default: cond_val = 1'b0;
        endcase
    end

    assign bus.fr          = fr_reg;
    assign bus.cond_true   = cond_val;
    assign bus.stack_full  = is_full;
    assign bus.stack_empty = is_empty;
    assign bus.stack_err   = err_reg;
endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: directed vector table, reset corner cases, and a
// randomized run against a queue-based model of the flag register and stack.
module tb_flag_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flag_unit_if #(.FLAG_W(4)) bus ();
    flag_unit #(.FLAG_W(4), .STACK_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    localparam int DEPTH = 4;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       push, pop, ld, we, clr;
        logic [3:0] mask, alu, wdata, cond;
        logic [3:0] e_fr;
        logic       e_ct, e_full, e_empty, e_err;
    } vec_t;

    vec_t vecs[$];

    logic [3:0] m_fr;
    logic       m_err;
    logic [3:0] m_stk[$];

    function automatic vec_t mk(input logic push, pop, ld, we, clr,
                                input logic [3:0] mask, alu, wdata, cond, e_fr,
                                input logic e_ct, e_full, e_empty, e_err);
        vec_t v;
        v.push = push; v.pop = pop; v.ld = ld; v.we = we; v.clr = clr;
        v.mask = mask; v.alu = alu; v.wdata = wdata; v.cond = cond;
        v.e_fr = e_fr; v.e_ct = e_ct; v.e_full = e_full; v.e_empty = e_empty; v.e_err = e_err;
        return v;
    endfunction

    // Condition truth taken from the flag meanings: signed/unsigned relations after SUB.
    function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v, lt_s;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        lt_s = n ^ v;
        case (c)
            4'h0: return 1'b1;
            4'h1: return z;
            4'h2: return !z;
            4'h3: return cy;
            4'h4: return !cy;
            4'h5: return n;
            4'h6: return !n;
            4'h7: return v;
            4'h8: return !v;
            4'h9: return !(cy || z);
            4'hA: return cy || z;
            4'hB: return !lt_s;
            4'hC: return lt_s;
            4'hD: return !(lt_s || z);
            4'hE: return lt_s || z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic push, pop, ld, we, clr,
                         input logic [3:0] mask, alu, wdata, cond);
        bus.push = push; bus.pop = pop; bus.fr_load = ld; bus.flag_we = we;
        bus.err_clr = clr; bus.flag_mask = mask; bus.alu_flags = alu;
        bus.fr_wdata = wdata; bus.cond = cond;
    endtask

    task automatic model_reset();
        m_fr = 4'h0;
        m_err = 1'b0;
        m_stk.delete();
    endtask

    // Evaluates one clock of the model from the inputs currently on the bus.
    task automatic model_step();
        logic [3:0] old_fr, nf;
        logic popped, e;
        old_fr = m_fr;
        popped = 1'b0;
        e = 1'b0;
        nf = old_fr;
        if (bus.push && bus.pop) begin
            if (m_stk.size() > 0) begin
                nf = m_stk[m_stk.size() - 1];
                m_stk[m_stk.size() - 1] = old_fr;
                popped = 1'b1;
            end else begin
                m_stk.push_back(old_fr);
                e = 1'b1;
            end
        end else if (bus.push) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(old_fr);
            else e = 1'b1;
        end else if (bus.pop) begin
            if (m_stk.size() > 0) begin
                nf = m_stk.pop_back();
                popped = 1'b1;
            end else begin
                e = 1'b1;
            end
        end
        if (!popped) begin
            if (bus.fr_load) nf = bus.fr_wdata;
            else if (bus.flag_we) nf = (old_fr & ~bus.flag_mask) | (bus.alu_flags & bus.flag_mask);
        end
        m_fr = nf;
        m_err = e ? 1'b1 : (bus.err_clr ? 1'b0 : m_err);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".fr"}, bus.fr, m_fr);
        chk({tag, ".cond_true"}, {3'b0, bus.cond_true}, {3'b0, cond_ref(m_fr, bus.cond)});
        chk({tag, ".full"}, {3'b0, bus.stack_full}, {3'b0, m_stk.size() == DEPTH});
        chk({tag, ".empty"}, {3'b0, bus.stack_empty}, {3'b0, m_stk.size() == 0});
        chk({tag, ".err"}, {3'b0, bus.stack_err}, {3'b0, m_err});
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".fr"}, bus.fr, 4'h0);
        chk({tag, ".empty"}, {3'b0, bus.stack_empty}, 4'h1);
        chk({tag, ".full"}, {3'b0, bus.stack_full}, 4'h0);
        chk({tag, ".err"}, {3'b0, bus.stack_err}, 4'h0);
    endtask

    initial begin
        // push pop ld we clr mask alu wdata cond | fr ct full empty err
        vecs.push_back(mk(0,0,0,1,0, 4'hF,4'hA,4'h0,4'h5, 4'hA,1,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 4'h0,4'h0,4'h0,4'h2, 4'hA,1,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 4'h0,4'h0,4'h0,4'hB, 4'hA,0,0,1,0));
        vecs.push_back(mk(0,0,1,0,0, 4'h0,4'h0,4'hF,4'h0, 4'hF,1,0,1,0));
        vecs.push_back(mk(0,0,0,1,0, 4'h4,4'h0,4'h0,4'h1, 4'hB,0,0,1,0));
        vecs.push_back(mk(0,0,1,1,0, 4'hF,4'h0,4'h1,4'h3, 4'h1,0,0,1,0));
        vecs.push_back(mk(1,0,1,0,0, 4'h0,4'h0,4'h2,4'h7, 4'h2,0,0,0,0));
        vecs.push_back(mk(1,0,1,0,0, 4'h0,4'h0,4'h4,4'h4, 4'h4,1,0,0,0));
        vecs.push_back(mk(1,0,1,0,0, 4'h0,4'h0,4'h8,4'h6, 4'h8,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 4'h0,4'h0,4'h0,4'hF, 4'h8,0,1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 4'h0,4'h0,4'h0,4'h0, 4'h8,1,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 4'h0,4'h0,4'h0,4'h5, 4'h8,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,0, 4'h0,4'h0,4'h0,4'h8, 4'h4,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,0, 4'h0,4'h0,4'h0,4'h3, 4'h2,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,0, 4'h0,4'h0,4'h0,4'h7, 4'h1,1,0,1,1));
        vecs.push_back(mk(0,0,0,0,1, 4'h0,4'h0,4'h0,4'h9, 4'h1,1,0,1,0));
        vecs.push_back(mk(0,1,0,1,0, 4'hF,4'h6,4'h0,4'hA, 4'h6,1,0,1,1));
        vecs.push_back(mk(0,0,0,0,1, 4'h0,4'h0,4'h0,4'h2, 4'h6,0,0,1,0));
        vecs.push_back(mk(0,0,1,0,0, 4'h0,4'h0,4'h7,4'h0, 4'h7,1,0,1,0));
        vecs.push_back(mk(1,0,1,0,0, 4'h0,4'h0,4'hC,4'h0, 4'hC,1,0,0,0));
        vecs.push_back(mk(1,0,1,0,0, 4'h0,4'h0,4'h3,4'hC, 4'h3,1,0,0,0));
        vecs.push_back(mk(1,1,0,0,0, 4'h0,4'h0,4'h0,4'hD, 4'hC,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 4'h0,4'h0,4'h0,4'hE, 4'h3,1,0,0,0));
        vecs.push_back(mk(0,0,0,1,0, 4'hF,4'hA,4'h0,4'h9, 4'hA,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 4'h0,4'h0,4'h0,4'hA, 4'hA,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 4'h0,4'h0,4'h0,4'hC, 4'hA,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 4'h0,4'h0,4'h0,4'hD, 4'hA,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 4'h0,4'h0,4'h0,4'hB, 4'hA,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 4'h0,4'h0,4'h0,4'h0, 4'h7,1,0,1,0));
        vecs.push_back(mk(1,1,0,0,0, 4'h0,4'h0,4'h0,4'h0, 4'h7,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,1, 4'h0,4'h0,4'h0,4'h0, 4'h7,1,0,1,0));

        rst = 1'b1;
        drive(0,0,0,0,0, 4'h0,4'h0,4'h0,4'h2);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_reset_state("reset");
        chk("reset.cond_ne", {3'b0, bus.cond_true}, 4'h1);
        $display("[TB] reset released fr=%h empty=%b", bus.fr, bus.stack_empty);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].push, vecs[i].pop, vecs[i].ld, vecs[i].we, vecs[i].clr,
                  vecs[i].mask, vecs[i].alu, vecs[i].wdata, vecs[i].cond);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.fr", i), bus.fr, vecs[i].e_fr);
            chk($sformatf("vec%0d.cond_true", i), {3'b0, bus.cond_true}, {3'b0, vecs[i].e_ct});
            chk($sformatf("vec%0d.full", i), {3'b0, bus.stack_full}, {3'b0, vecs[i].e_full});
            chk($sformatf("vec%0d.empty", i), {3'b0, bus.stack_empty}, {3'b0, vecs[i].e_empty});
            chk($sformatf("vec%0d.err", i), {3'b0, bus.stack_err}, {3'b0, vecs[i].e_err});
            $display("[TB] vec%0d push=%b pop=%b ld=%b we=%b cond=%h -> fr=%h ct=%b full=%b empty=%b err=%b",
                     i, vecs[i].push, vecs[i].pop, vecs[i].ld, vecs[i].we, vecs[i].cond,
                     bus.fr, bus.cond_true, bus.stack_full, bus.stack_empty, bus.stack_err);
        end

        // Load and save a value, then hit reset in the middle of a second push.
        drive(1,0,1,0,0, 4'h0,4'h0,4'hF,4'h0);
        @(posedge clk);
        #1;
        chk("prereset.fr", bus.fr, 4'hF);
        chk("prereset.empty", {3'b0, bus.stack_empty}, 4'h0);
        drive(1,0,0,0,0, 4'h0,4'h0,4'h0,4'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset_state("midreset");
        $display("[TB] async reset mid-push fr=%h empty=%b", bus.fr, bus.stack_empty);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0,0,0,0,0, 4'h0,4'h0,4'h0,4'h0);
        #1;
        check_reset_state("postreset");
        model_reset();

        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 40) % 2 == 0) ? 3 : 1;
            drive(4'($urandom_range(0, 3)) < 4'(bias),
                  4'($urandom_range(0, 3)) < 4'(4 - bias),
                  $urandom_range(0, 5) == 0,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0,
                  4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            model_step();
            @(posedge clk);
            #1;
            check_model($sformatf("rnd%0d", i));
            $display("[TB] rnd%0d push=%b pop=%b ld=%b we=%b cond=%h -> fr=%h ct=%b depth=%0d err=%b",
                     i, bus.push, bus.pop, bus.fr_load, bus.flag_we, bus.cond,
                     bus.fr, bus.cond_true, m_stk.size(), bus.stack_err);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
